dbg_view_seq: RTL

Debug-view sequencer for the single-cycle RISC-V CPU top. It time-shares one read-only debug port across four on-chip sources: the current instruction, the register file, the ALU probe (A/B/C/Zero) and data memory. On each `step` pulse it fetches the next word from the source selected by the switches, using a req/ack handshake. It holds that word steady for the 7-segment driver. It replaces the ad-hoc display-cycling logic in the top level with one arbitrated, per-source-indexed controller.

---
 rtl/dbg_view_seq.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/dbg_view_seq.sv
// Debug-view sequencer: time-shares one read-only debug port across the
// instruction, register-file, ALU-probe and data-memory sources, one word per step.
module dbg_view_seq #(
  parameter int          REG_NUM      = 11,
  parameter int          ALU_NUM      = 4,
  parameter int          DMEM_NUM     = 16,
  parameter int          TIMEOUT      = 15,
  parameter logic [31:0] DEFAULT_DATA = 32'h76543210,
  parameter logic [31:0] ERR_DATA     = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        step,
  input  logic [3:0]  sel,
  input  logic        dbg_ack,
  input  logic [31:0] dbg_rdata,
  output logic        dbg_req,
  output logic [1:0]  dbg_src,
  output logic [4:0]  dbg_addr,
  output logic [31:0] disp_data,
  output logic        busy,
  output logic        err
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t             r_state;
  logic               r_req;
  logic [1:0]         r_src;
  logic [4:0]         r_addr;
  logic [31:0]        r_disp;
  logic               r_busy;
  logic               r_err;
  logic [4:0]         r_rf_idx;
  logic [4:0]         r_alu_idx;
  logic [4:0]         r_dm_idx;
  logic [CNT_W-1:0]   r_wait_cnt;

  logic               w_sel_valid;
  logic [1:0]         w_sel_src;
  logic [4:0]         w_sel_idx;

  // Wrapping index advance; never yields an index at or beyond num.
  function automatic logic [4:0] next_idx(input logic [4:0] idx, input int num);
    if (idx >= 5'(num - 1)) begin
      next_idx = 5'd0;
    end else begin
      next_idx = idx + 5'd1;
    end
  endfunction

  // Decode the one-hot source switches into a source code and its current index.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_src   = 2'd0;
    w_sel_idx   = 5'd0;
    case (sel)
      4'b1000: begin
        w_sel_valid = 1'b1;
        w_sel_src   = 2'd0;
        w_sel_idx   = 5'd0;
      end
      4'b0100: begin
        w_sel_valid = 1'b1;
        w_sel_src   = 2'd1;
        w_sel_idx   = r_rf_idx;
      end
      4'b0010: begin
        w_sel_valid = 1'b1;
        w_sel_src   = 2'd2;
        w_sel_idx   = r_alu_idx;
      end
      4'b0001: begin
        w_sel_valid = 1'b1;
        w_sel_src   = 2'd3;
        w_sel_idx   = r_dm_idx;
      end
      default: begin
        w_sel_valid = 1'b0;
        w_sel_src   = 2'd0;
        w_sel_idx   = 5'd0;
      end
    endcase
  end

  // Request FSM with registered handshake, display and per-source indices.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= ST_IDLE;
      r_req      <= 1'b0;
      r_src      <= 2'd0;
      r_addr     <= 5'd0;
      r_disp     <= DEFAULT_DATA;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
      r_rf_idx   <= 5'd0;
      r_alu_idx  <= 5'd0;
      r_dm_idx   <= 5'd0;
      r_wait_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (step) begin
            if (w_sel_valid) begin
              r_src      <= w_sel_src;
              r_addr     <= w_sel_idx;
              r_req      <= 1'b1;
              r_busy     <= 1'b1;
              r_wait_cnt <= '0;
              r_state    <= ST_REQ;
            end else begin
              r_disp <= DEFAULT_DATA;
            end
          end
        end
        ST_REQ: begin
          if (dbg_ack) begin
            r_disp  <= dbg_rdata;
            r_err   <= 1'b0;
            r_req   <= 1'b0;
            r_state <= ST_WAIT;
            case (r_src)
              2'd1:    r_rf_idx  <= next_idx(r_rf_idx, REG_NUM);
              2'd2:    r_alu_idx <= next_idx(r_alu_idx, ALU_NUM);
              2'd3:    r_dm_idx  <= next_idx(r_dm_idx, DMEM_NUM);
              default: r_rf_idx  <= r_rf_idx;
            endcase
          end else if (r_wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            // Give up: show the error word and leave the index where it was.
            r_disp  <= ERR_DATA;
            r_err   <= 1'b1;
            r_req   <= 1'b0;
            r_state <= ST_WAIT;
          end else begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
          end
        end
        ST_WAIT: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_req   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign dbg_req   = r_req;
  assign dbg_src   = r_src;
  assign dbg_addr  = r_addr;
  assign disp_data = r_disp;
  assign busy      = r_busy;
  assign err       = r_err;

endmodule
